// File: rtl/abc_seq_driver.sv
// Purpose : initiator for the a/b/c -> d handshake. It drives a programmed sequence
//           of 3-bit steps onto a/b/c, then waits a bounded time for d to reach the
//           expected level and reports pass or timeout.
// Latency : step 0 appears 1 cycle after start. Each step is held max(hold,1) cycles.
//           done_o pulses 1 cycle after the decisive d sample.
// Backpressure : none. start_i is accepted only in IDLE and is otherwise dropped (not queued).
// Ports   : clk/rst_n (async active-low); start_i, pattern_i, hold_i, expect_i, timeout_i
//           are latched on start; d_i is the responder return line; a_o/b_o/c_o are the
//           driven lines; busy_o, done_o, pass_o, timeout_o report status.
module abc_seq_driver #(
  parameter int STEPS  = 4,
  parameter int HOLD_W = 4,
  parameter int TO_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [3*STEPS-1:0]   pattern_i,
  input  logic [HOLD_W-1:0]    hold_i,
  input  logic                 expect_i,
  input  logic [TO_W-1:0]      timeout_i,
  input  logic                 d_i,
  output logic                 a_o,
  output logic                 b_o,
  output logic                 c_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;

  state_t               state;
  logic [3*STEPS-1:0]   pat_q;
  logic [HOLD_W-1:0]    hold_q;
  logic                 exp_q;
  logic [TO_W-1:0]      to_q;
  logic [SW-1:0]        step_q;
  logic [HOLD_W-1:0]    hcnt_q;
  logic [TO_W-1:0]      wcnt_q;

  logic [SW-1:0]        step_nxt;
  logic [2:0]           nxt_bits;

  assign step_nxt = step_q + 1'b1;

  // Pattern slice for the following step; a mux over constant slices keeps the
  // index arithmetic out of the datapath.
  always_comb begin
    nxt_bits = pat_q[2:0];
    for (int k = 0; k < STEPS; k++) begin
      if (SW'(k) == step_nxt) nxt_bits = pat_q[3*k +: 3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_q     <= '0;
      hold_q    <= '0;
      exp_q     <= 1'b0;
      to_q      <= '0;
      step_q    <= '0;
      hcnt_q    <= '0;
      wcnt_q    <= '0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      c_o       <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            pat_q     <= pattern_i;
            // A hold of 0 behaves exactly like a hold of 1.
            hold_q    <= (hold_i == '0) ? HOLD_W'(1) : hold_i;
            exp_q     <= expect_i;
            to_q      <= timeout_i;
            step_q    <= '0;
            hcnt_q    <= '0;
            wcnt_q    <= '0;
            pass_o    <= 1'b0;
            timeout_o <= 1'b0;
            busy_o    <= 1'b1;
            {c_o, b_o, a_o} <= pattern_i[2:0];
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (hcnt_q == hold_q - 1'b1) begin
            hcnt_q <= '0;
            if (step_q == LAST_STEP) begin
              // The last step's value stays on a/b/c throughout WAIT.
              state <= WAIT;
            end else begin
              step_q <= step_nxt;
              {c_o, b_o, a_o} <= nxt_bits;
            end
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        WAIT: begin
          // A match is checked first, so it wins over expiry on the final sample.
          if (d_i == exp_q) begin
            state     <= DONE;
            pass_o    <= 1'b1;
            timeout_o <= 1'b0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            {c_o, b_o, a_o} <= 3'b000;
          end else if (wcnt_q == to_q) begin
            state     <= DONE;
            pass_o    <= 1'b0;
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            {c_o, b_o, a_o} <= 3'b000;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
